// File: rtl/inject_sched.sv
// inject_sched: sweeps a masked set of injection buffers in ascending index
// order. Each buffer gets one enable pulse, then up to BURST_LEN words are
// forwarded to the router input with a one-cycle registered latency. A buffer
// that never starts within TIMEOUT cycles, or that drops valid mid-burst, is
// flagged in the sticky err vector and the sweep moves on to the next buffer.
//
// Handshake: src_valid[i] qualifies src_data word i in the cycle it is high;
// there is no back-pressure toward the buffers. flit_valid qualifies flit_out
// for exactly the cycle it is high. Only the buffer selected by cur_src is
// observed; valid from every other buffer is ignored.
module inject_sched #(
    parameter int NSRC      = 4,
    parameter int BURST_LEN = 30,
    parameter int TIMEOUT   = 15,
    localparam int SW       = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NSRC-1:0]      src_mask,
    input  logic [NSRC-1:0]      src_valid,
    input  logic [20*NSRC-1:0]   src_data,
    output logic [NSRC-1:0]      src_enable,
    output logic [19:0]          flit_out,
    output logic                 flit_valid,
    output logic [SW-1:0]        cur_src,
    output logic                 busy,
    output logic                 done,
    output logic [NSRC-1:0]      err,
    output logic [2:0]           state_dbg
);

    // ptr may point one past the last buffer, so it needs an extra code.
    localparam int PW = $clog2(NSRC + 1);
    // Counter widths include headroom so the terminal value never wraps.
    localparam int CW = $clog2(BURST_LEN + 2);
    localparam int TW = $clog2(TIMEOUT + 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_ENABLE = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_STREAM = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]      state_q,      state_d;
    logic [NSRC-1:0] pending_q,    pending_d;
    logic [PW-1:0]   ptr_q,        ptr_d;
    logic [SW-1:0]   cur_src_q,    cur_src_d;
    logic [CW-1:0]   count_q,      count_d;
    logic [TW-1:0]   timer_q,      timer_d;
    logic [NSRC-1:0] err_q,        err_d;
    logic [19:0]     flit_out_q,   flit_out_d;
    logic            flit_valid_q, flit_valid_d;

    logic            sel_found;
    logic [SW-1:0]   sel_idx;
    logic            cur_valid;
    logic [19:0]     cur_word;
    logic [CW-1:0]   count_inc;
    logic [TW-1:0]   timer_inc;
    logic [PW-1:0]   ptr_next;

    assign cur_valid = src_valid[cur_src_q];
    assign cur_word  = src_data[20*cur_src_q +: 20];
    assign count_inc = count_q + CW'(1);
    assign timer_inc = timer_q + TW'(1);
    assign ptr_next  = PW'(cur_src_q) + PW'(1);

    // Lowest pending buffer at or above ptr; scanning downward lets the lowest win.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pending_q[i] && (PW'(i) >= ptr_q)) begin
                sel_found = 1'b1;
                sel_idx   = SW'(i);
            end
        end
    end

    // Sweep sequencing, burst accounting and flit capture.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        ptr_d        = ptr_q;
        cur_src_d    = cur_src_q;
        count_d      = count_q;
        timer_d      = timer_q;
        err_d        = err_q;
        flit_out_d   = flit_out_q;
        flit_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pending_d = src_mask;
                    err_d     = '0;
                    ptr_d     = '0;
                    state_d   = (src_mask == '0) ? S_DONE : S_SELECT;
                end
            end
            S_SELECT: begin
                if (sel_found) begin
                    cur_src_d = sel_idx;
                    state_d   = S_ENABLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_ENABLE: begin
                timer_d = '0;
                count_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A word arriving on the last permitted cycle still wins over the timeout.
                if (cur_valid) begin
                    flit_out_d   = cur_word;
                    flit_valid_d = 1'b1;
                    count_d      = CW'(1);
                    if (BURST_LEN == 1) begin
                        pending_d[cur_src_q] = 1'b0;
                        ptr_d                = ptr_next;
                        state_d              = S_SELECT;
                    end else begin
                        state_d = S_STREAM;
                    end
                end else if (timer_inc == TW'(TIMEOUT)) begin
                    err_d[cur_src_q]     = 1'b1;
                    pending_d[cur_src_q] = 1'b0;
                    ptr_d                = ptr_next;
                    state_d              = S_SELECT;
                end else begin
                    timer_d = timer_inc;
                end
            end
            S_STREAM: begin
                if (cur_valid) begin
                    flit_out_d   = cur_word;
                    flit_valid_d = 1'b1;
                    count_d      = count_inc;
                    if (count_inc == CW'(BURST_LEN)) begin
                        pending_d[cur_src_q] = 1'b0;
                        ptr_d                = ptr_next;
                        state_d              = S_SELECT;
                    end
                end else begin
                    // Short burst: flag the buffer and move past it.
                    err_d[cur_src_q]     = 1'b1;
                    pending_d[cur_src_q] = 1'b0;
                    ptr_d                = ptr_next;
                    state_d              = S_SELECT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pending_q    <= '0;
            ptr_q        <= '0;
            cur_src_q    <= '0;
            count_q      <= '0;
            timer_q      <= '0;
            err_q        <= '0;
            flit_out_q   <= '0;
            flit_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            ptr_q        <= ptr_d;
            cur_src_q    <= cur_src_d;
            count_q      <= count_d;
            timer_q      <= timer_d;
            err_q        <= err_d;
            flit_out_q   <= flit_out_d;
            flit_valid_q <= flit_valid_d;
        end
    end

    // Enable pulse is decoded from state so it is one cycle wide and clears with reset.
    always_comb begin
        src_enable = '0;
        if (state_q == S_ENABLE) begin
            src_enable[cur_src_q] = 1'b1;
        end
    end

    assign flit_out   = flit_out_q;
    assign flit_valid = flit_valid_q;
    assign cur_src    = cur_src_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign state_dbg  = state_q;

endmodule

// File: doc/inject_sched.md
INJECT_SCHED -- requirements
Module: inject_sched

Interface
REQ-001 SHALL have parameter NSRC, default 4, meaning the number of injection buffers sequenced.
REQ-002 SHALL have parameter BURST_LEN, default 30, meaning the number of words per buffer burst.
REQ-003 SHALL have parameter TIMEOUT, default 15, meaning the maximum cycles to wait for a first valid word after enable.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit: a one-cycle request to begin an injection sweep.
REQ-007 SHALL have port src_mask, input, NSRC bits: the buffers to include in the sweep; sampled only when start is accepted.
REQ-008 SHALL have port src_valid, input, NSRC bits: the per-buffer word-valid signals (out_valid).
REQ-009 SHALL have port src_data, input, 20*NSRC bits: the per-buffer words; buffer i occupies bits [20*i+19:20*i].
REQ-010 SHALL have port src_enable, output, NSRC bits: per-buffer enable pulses.
REQ-011 SHALL have port flit_out, output, 20 bits: the forwarded flit to the router input.
REQ-012 SHALL have port flit_valid, output, 1 bit: qualifies flit_out.
REQ-013 SHALL have port cur_src, output, clog2(NSRC) bits: the index of the buffer currently served.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port done, output, 1 bit: a one-cycle pulse at the end of a sweep.
REQ-016 SHALL have port err, output, NSRC bits: sticky per-buffer fault flags, cleared on accepted start.

Function
REQ-017 SHALL implement the FSM states IDLE, SELECT, ENABLE, WAIT, STREAM and DONE.
REQ-018 SHALL, in IDLE with start=1, latch src_mask into a pending register, clear err, set ptr=0 and go to SELECT; if src_mask=0, SHALL go directly to DONE.
REQ-019 SHALL ignore start in any state other than IDLE.
REQ-020 SHALL, in SELECT, choose the lowest pending index >= ptr as cur_src and go to ENABLE; if no pending bit remains, SHALL go to DONE.
REQ-021 SHALL, in ENABLE, drive src_enable[cur_src]=1 for exactly one cycle with all other bits 0, clear the timer and word count, and go to WAIT.
REQ-022 SHALL, in WAIT, on src_valid[cur_src]=1 set count=1 and go to STREAM; otherwise increment the timer.
REQ-023 SHALL, in WAIT, when the timer reaches TIMEOUT, set err[cur_src], clear its pending bit, set ptr=cur_src+1 and go to SELECT.
REQ-024 SHALL, in STREAM, increment count on each src_valid[cur_src]=1 cycle.
REQ-025 SHALL, in STREAM, when count reaches BURST_LEN, clear the pending bit, set ptr=cur_src+1 and go to SELECT.
REQ-026 SHALL, in STREAM, when src_valid[cur_src]=0 before count reaches BURST_LEN, set err[cur_src], clear the pending bit and go to SELECT.
REQ-027 SHALL register flit_out<=src_data[cur_src] and flit_valid<=1 when in WAIT or STREAM with src_valid[cur_src]=1, giving a latency of exactly 1 cycle; otherwise flit_valid<=0 and flit_out holds its value.
REQ-028 SHALL ignore src_valid from non-selected buffers and SHALL forward at most BURST_LEN flits per buffer.
REQ-029 SHALL, in DONE, assert done for 1 cycle and return to IDLE.
REQ-030 SHALL keep count and timer wide enough for BURST_LEN and TIMEOUT with no wrap-around.

Reset
REQ-031 SHALL, on rst=0 at any time including mid-sweep, immediately set state=IDLE and force src_enable=0, flit_out=0, flit_valid=0, cur_src=0, busy=0, done=0, err=0, and clear pending, ptr, count and timer.
REQ-032 SHALL, after rst rises, require a new start before any enable is issued.

Verification
REQ-033 Bench SHALL cover: mask=4'b1111 with four compliant 30-word buffers -> 120 flits in order buf0..buf3, one src_enable pulse each, done=1 once, err=0.
REQ-034 Bench SHALL cover: mask=4'b0101 -> only buffers 0 and 2 enabled, 60 flits, buffers 1 and 3 never enabled.
REQ-035 Bench SHALL cover: mask=0 -> done pulses 1 cycle after start, with no src_enable asserted.
REQ-036 Bench SHALL cover: buffer 1 silent -> err[1]=1 after 15 WAIT cycles, then buffer 2 served normally.
REQ-037 Bench SHALL cover: buffer 0 stops after 10 words -> err[0]=1, 10 flits forwarded, and the sweep continues.
REQ-038 Bench SHALL cover: rst=0 asserted during buffer 2 STREAM -> all outputs 0 asynchronously, a start pulse during reset is ignored, and a fresh start after reset is accepted.
